// File: rtl/ga_image_loader.sv
// Serial command front end for the morphologic GA: frames, shadow images,
// checksum-gated commit, run/reset control and a one-byte ACK/NAK reply.
module ga_image_loader #(
    parameter int ImageWidth   = 8,
    parameter int ImageHeight  = 4,
    parameter int PayloadBytes = (ImageWidth * ImageHeight + 7) / 8,
    parameter int TimeoutWidth = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rxData,
    input  logic                              rxValid,
    output logic [7:0]                        txData,
    output logic                              txValid,
    input  logic                              txReady,
    output logic [ImageWidth*ImageHeight-1:0] origin,
    output logic [ImageWidth*ImageHeight-1:0] objetive,
    output logic                              run,
    output logic                              gaRst,
    output logic                              overrun
);

    localparam int N  = ImageWidth * ImageHeight;
    localparam int SW = PayloadBytes * 8;
    localparam int IW = $clog2(PayloadBytes + 1);

    localparam logic [7:0] SYNC   = 8'h55;
    localparam logic [7:0] LOAD_O = 8'h4F;
    localparam logic [7:0] LOAD_B = 8'h54;
    localparam logic [7:0] START  = 8'h53;
    localparam logic [7:0] STOP   = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_CHECK,
        S_RESPOND
    } state_t;

    state_t                  state;
    logic [7:0]              cmd;
    logic [7:0]              acc;
    logic [IW-1:0]           idx;
    logic [SW-1:0]           shadow;
    logic [TimeoutWidth-1:0] tmo;
    logic                    loaded_o;
    logic                    loaded_b;
    logic [N-1:0]            image;

    // Pad bits of the last payload byte sit below the image and are dropped.
    assign image = shadow[SW-1 -: N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cmd      <= '0;
            acc      <= '0;
            idx      <= '0;
            shadow   <= '0;
            tmo      <= '0;
            loaded_o <= 1'b0;
            loaded_b <= 1'b0;
            origin   <= '0;
            objetive <= '0;
            run      <= 1'b0;
            gaRst    <= 1'b0;
            txData   <= '0;
            txValid  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            gaRst <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    tmo <= '0;
                    if (rxValid && rxData == SYNC) begin
                        state <= S_CMD;
                    end
                end
                S_RESPOND: begin
                    if (rxValid) begin
                        overrun <= 1'b1;
                    end
                    if (txReady) begin
                        txValid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    if (!rxValid) begin
                        if (tmo == '1) begin
                            tmo   <= '0;
                            state <= S_IDLE;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end else begin
                        tmo <= '0;
                        if (state == S_CMD) begin
                            cmd <= rxData;
                            acc <= rxData;
                            idx <= '0;
                            if (rxData == LOAD_O || rxData == LOAD_B) begin
                                state <= S_PAYLOAD;
                            end else begin
                                state <= S_CHECK;
                            end
                        end else if (state == S_PAYLOAD) begin
                            for (int k = 0; k < PayloadBytes; k++) begin
                                if (idx == IW'(k)) begin
                                    shadow[SW-1-8*k -: 8] <= rxData;
                                end
                            end
                            acc <= acc ^ rxData;
                            idx <= idx + 1'b1;
                            if (idx == IW'(PayloadBytes - 1)) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            state   <= S_RESPOND;
                            txValid <= 1'b1;
                            txData  <= NAK;
                            if (rxData == acc) begin
                                if (cmd == LOAD_O) begin
                                    origin   <= image;
                                    loaded_o <= 1'b1;
                                    run      <= 1'b0;
                                    txData   <= ACK;
                                end else if (cmd == LOAD_B) begin
                                    objetive <= image;
                                    loaded_b <= 1'b1;
                                    run      <= 1'b0;
                                    txData   <= ACK;
                                end else if (cmd == START) begin
                                    if (loaded_o && loaded_b) begin
                                        run    <= 1'b1;
                                        gaRst  <= 1'b1;
                                        txData <= ACK;
                                    end
                                end else if (cmd == STOP) begin
                                    run    <= 1'b0;
                                    txData <= ACK;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ga_image_loader.sv
// Bench for ga_image_loader: frame-level reference model, per-cycle compare,
// directed command scenarios followed by randomized framed traffic.
module tb_ga_image_loader;

    localparam int TW = 8;
    localparam int N  = 32;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rxData = 8'h00;
    logic          rxValid = 1'b0;
    logic          txReady = 1'b0;
    logic [7:0]    txData;
    logic          txValid;
    logic [N-1:0]  origin;
    logic [N-1:0]  objetive;
    logic          run;
    logic          gaRst;
    logic          overrun;

    ga_image_loader #(
        .ImageWidth  (8),
        .ImageHeight (4),
        .TimeoutWidth(TW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxData  (rxData),
        .rxValid (rxValid),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady),
        .origin  (origin),
        .objetive(objetive),
        .run     (run),
        .gaRst   (gaRst),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_origin, m_obj;
    logic         m_lo, m_lb, m_run, m_garst, m_txv, m_ovr, m_in;
    logic [7:0]   m_txd;
    logic [7:0]   q[$];
    int           m_idle;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual %h expected %h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic void mreset();
        m_origin = '0; m_obj = '0; m_lo = 0; m_lb = 0; m_run = 0;
        m_garst = 0; m_txv = 0; m_ovr = 0; m_in = 0; m_txd = 8'h00;
        m_idle = 0;
        q.delete();
    endfunction

    function automatic int need(logic [7:0] c);
        return (c == 8'h4F || c == 8'h54) ? PB + 2 : 2;
    endfunction

    function automatic logic [N-1:0] img();
        logic [PB*8-1:0] w;
        w = '0;
        for (int i = 0; i < PB; i++) w = {w[PB*8-9:0], q[1+i]};
        return w[PB*8-1 -: N];
    endfunction

    function automatic void eval_frame();
        logic [7:0] x;
        logic [7:0] c;
        x = 8'h00;
        for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
        c = q[0];
        m_txd = 8'h15;
        if (x == q[q.size()-1]) begin
            if (c == 8'h4F) begin
                m_origin = img(); m_lo = 1; m_run = 0; m_txd = 8'h06;
            end else if (c == 8'h54) begin
                m_obj = img(); m_lb = 1; m_run = 0; m_txd = 8'h06;
            end else if (c == 8'h53) begin
                if (m_lo && m_lb) begin
                    m_run = 1; m_garst = 1; m_txd = 8'h06;
                end
            end else if (c == 8'h52) begin
                m_run = 0; m_txd = 8'h06;
            end
        end
        m_txv = 1;
    endfunction

    // one clock edge: drive, then advance the model by what that edge consumes
    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy);
        @(negedge clk);
        rxValid = v; rxData = d; txReady = rdy;
        @(posedge clk);
        #1;
        m_garst = 0;
        if (m_txv) begin
            if (v) m_ovr = 1;
            if (rdy) m_txv = 0;
        end else if (!m_in) begin
            if (v && d == 8'h55) begin
                m_in = 1; q.delete(); m_idle = 0;
            end
        end else if (v) begin
            q.push_back(d);
            m_idle = 0;
            if (q.size() == need(q[0])) begin
                eval_frame();
                m_in = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == (1 << TW)) m_in = 0;
        end
        rxValid = 0;
    endtask

    always @(negedge clk) begin
        chk("origin", origin, m_origin);
        chk("objetive", objetive, m_obj);
        chk("run", 32'(run), 32'(m_run));
        chk("gaRst", 32'(gaRst), 32'(m_garst));
        chk("txValid", 32'(txValid), 32'(m_txv));
        chk("txData", 32'(txData), 32'(m_txd));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic send_bytes(input logic [7:0] b[$], input int gap);
        foreach (b[i]) begin
            repeat ($urandom_range(gap, 0)) cyc(0, 8'h00, 1'($urandom));
            cyc(1, b[i], 1'($urandom));
        end
    endtask

    task automatic drain(input bit strays);
        int guard = 0;
        while (m_txv && guard < 200) begin
            cyc(strays && ($urandom % 8 == 0), 8'($urandom), ($urandom % 3) != 0);
            guard++;
        end
        if (m_txv) chk("drain_timeout", 32'(m_txv), 32'(0));
    endtask

    task automatic reset_now();
        @(posedge clk);
        #2 rst = 0;
        #1 mreset();
        chk("rst_origin", origin, 32'h0);
        chk("rst_run", 32'(run), 32'(0));
        chk("rst_txValid", 32'(txValid), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    logic [7:0] fr[$];

    initial begin
        mreset();
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        chk("init_txData", 32'(txData), 32'h0);

        // load origin
        fr = '{8'h55, 8'h4F, 8'h00, 8'h10, 8'h00, 8'h00, 8'h5F};
        send_bytes(fr, 2);
        chk("lo_origin", origin, 32'h00100000);
        chk("lo_ack", 32'(txData), 32'h06);
        chk("lo_txv", 32'(txValid), 32'h1);
        chk("lo_run", 32'(run), 32'h0);
        drain(0);

        // load objective then start
        fr = '{8'h55, 8'h54, 8'h38, 8'h7C, 8'h38, 8'h10, 8'h38};
        send_bytes(fr, 0);
        chk("lb_obj", objetive, 32'h387C3810);
        chk("lb_ack", 32'(txData), 32'h06);
        drain(0);
        fr = '{8'h55, 8'h53, 8'h53};
        send_bytes(fr, 1);
        chk("st_run", 32'(run), 32'h1);
        chk("st_garst", 32'(gaRst), 32'h1);
        chk("st_ack", 32'(txData), 32'h06);
        cyc(0, 8'h00, 1);
        chk("st_garst_low", 32'(gaRst), 32'h0);

        // bad checksum
        fr = '{8'h55, 8'h4F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        send_bytes(fr, 1);
        chk("bad_nak", 32'(txData), 32'h15);
        chk("bad_origin", origin, 32'h00100000);
        chk("bad_run", 32'(run), 32'h1);
        drain(0);

        // reload origin while running stops the GA
        fr = '{8'h55, 8'h4F, 8'h00, 8'h10, 8'h00, 8'h00, 8'h5F};
        send_bytes(fr, 0);
        chk("rl_run", 32'(run), 32'h0);
        chk("rl_ack", 32'(txData), 32'h06);
        drain(0);

        // start before both images are loaded
        reset_now();
        fr = '{8'h55, 8'h53, 8'h53};
        send_bytes(fr, 0);
        chk("early_nak", 32'(txData), 32'h15);
        chk("early_run", 32'(run), 32'h0);
        chk("early_garst", 32'(gaRst), 32'h0);
        drain(0);

        // timeout drops the frame silently
        fr = '{8'h55, 8'h4F, 8'h12};
        send_bytes(fr, 0);
        repeat (1 << TW) cyc(0, 8'h00, 1);
        chk("to_txv", 32'(txValid), 32'h0);
        fr = '{8'h55, 8'h52, 8'h52};
        send_bytes(fr, 0);
        chk("to_ack", 32'(txData), 32'h06);
        drain(0);

        // one cycle short of the timeout still completes the frame
        cyc(1, 8'h55, 1);
        cyc(1, 8'h52, 1);
        repeat ((1 << TW) - 1) cyc(0, 8'h00, 1);
        cyc(1, 8'h52, 0);
        chk("edge_txv", 32'(txValid), 32'h1);
        chk("edge_ack", 32'(txData), 32'h06);

        // backpressure with bytes dropped
        for (int i = 0; i < 20; i++) cyc(i % 5 == 3, 8'h55, 0);
        chk("bp_txv", 32'(txValid), 32'h1);
        chk("bp_txd", 32'(txData), 32'h06);
        chk("bp_ovr", 32'(overrun), 32'h1);
        cyc(0, 8'h00, 1);
        chk("bp_release", 32'(txValid), 32'h0);

        // reset mid-frame loses the frame
        fr = '{8'h55, 8'h4F, 8'h00};
        send_bytes(fr, 0);
        reset_now();
        fr = '{8'h10, 8'h00, 8'h00, 8'h5F};
        send_bytes(fr, 0);
        chk("mid_txv", 32'(txValid), 32'h0);
        chk("mid_origin", origin, 32'h0);

        // randomized traffic
        for (int f = 0; f < 150; f++) begin
            logic [7:0] c, x;
            int sel;
            sel = $urandom % 6;
            c = (sel == 0) ? 8'h4F : (sel == 1) ? 8'h54 :
                (sel == 2 || sel == 3) ? 8'h53 : (sel == 4) ? 8'h52 :
                8'($urandom);
            fr = '{8'h55, c};
            x = c;
            if (c == 8'h4F || c == 8'h54) begin
                for (int i = 0; i < PB; i++) begin
                    logic [7:0] b;
                    b = ($urandom % 6 == 0) ? 8'h55 : 8'($urandom);
                    fr.push_back(b);
                    x ^= b;
                end
            end
            if ($urandom % 7 == 0) x ^= 8'($urandom_range(255, 1));
            fr.push_back(x);
            if ($urandom % 10 == 0) cyc(1, 8'($urandom), 1);
            if ($urandom % 20 == 0) begin
                cyc(1, 8'h55, 1);
                repeat ((1 << TW) - 2 + $urandom_range(4, 0)) cyc(0, 8'h00, 1);
            end
            send_bytes(fr, 2);
            drain(1);
        end

        repeat (3) cyc(0, 8'h00, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
